c7bbiu_icu_rd: RTL

- Instruction-side read engine of the BIU; sits directly downstream of the I-cache unit.
- Accepts the cache's line-fill or single-beat read request (icu_biu_req/addr/single) and issues one AXI4 read burst.
- Returns beats to the cache as biu_icu_data_valid/data/last/fault.
- One transaction outstanding at a time; the cache holds off further requests until the last beat.

---
 rtl/c7bbiu_icu_rd.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/c7bbiu_icu_rd.sv
// Instruction-side AXI4 read engine: one I-cache line fill or single beat per request.
// Optional watchdog enabled by defining C7B_BIU_IRD_TIMEOUT_EN.
module c7bbiu_icu_rd #(
    parameter int LINE_BEATS     = 4,
    parameter int ARID_W         = 4,
    parameter int ICU_ARID       = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icu_biu_req,
    input  logic [28:0]       icu_biu_addr,
    input  logic              icu_biu_single,
    output logic              biu_icu_ack,
    output logic              biu_icu_data_valid,
    output logic              biu_icu_data_last,
    output logic [63:0]       biu_icu_data,
    output logic              biu_icu_fault,
    output logic              arvalid,
    input  logic              arready,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [ARID_W-1:0] arid,
    input  logic              rvalid,
    output logic              rready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [ARID_W-1:0] rid
);

    localparam int         CNT_W    = (LINE_BEATS > 2) ? $clog2(LINE_BEATS) : 1;
    localparam logic [7:0] FILL_LEN = 8'(LINE_BEATS - 1);

    typedef enum logic [1:0] {IDLE, AR, RD} state_t;

    state_t           state, state_nxt;
    logic [28:0]      addr_q;
    logic [7:0]       len_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             r_hs;
    logic             cnt_at_len;
    logic             beat_last;
    logic             beat_fault;
    logic             timeout;

    // rid is unused (sole master on this ID); only rresp[1] signals an error.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp[0]};

    assign araddr  = {addr_q, 3'b000};
    assign arlen   = len_q;
    assign arsize  = 3'b011;
    assign arburst = 2'b01;
    assign arid    = ARID_W'(ICU_ARID);

    assign r_hs       = rvalid & rready;
    assign cnt_at_len = (8'(cnt_q) == len_q);
    // A beat ends the burst on rlast or when the count is exhausted; any disagreement is a fault.
    assign beat_last  = rlast | cnt_at_len;
    assign beat_fault = rresp[1] | (beat_last & (err_q | (rlast ^ cnt_at_len)));

`ifdef C7B_BIU_IRD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            ar_hs;

    assign ar_hs   = arvalid & arready;
    assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !ar_hs && !r_hs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == IDLE || ar_hs || r_hs) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        biu_icu_ack = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        case (state)
            IDLE: begin
                biu_icu_ack = icu_biu_req & ~reset;
                if (icu_biu_req) state_nxt = AR;
            end
            AR: begin
                arvalid = 1'b1;
                if (timeout)      state_nxt = IDLE;
                else if (arready) state_nxt = RD;
            end
            RD: begin
                rready = 1'b1;
                if (timeout)                state_nxt = IDLE;
                else if (rvalid && beat_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: every register here is a small control/data flop, so all of them take the async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q             <= '0;
            len_q              <= '0;
            cnt_q              <= '0;
            err_q              <= 1'b0;
            biu_icu_data       <= '0;
            biu_icu_data_valid <= 1'b0;
            biu_icu_data_last  <= 1'b0;
            biu_icu_fault      <= 1'b0;
        end else begin
            biu_icu_data_valid <= 1'b0;
            biu_icu_data_last  <= 1'b0;
            biu_icu_fault      <= 1'b0;
            if (biu_icu_ack) begin
                addr_q <= icu_biu_addr;
                len_q  <= icu_biu_single ? 8'd0 : FILL_LEN;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end
            if (r_hs) begin
                biu_icu_data       <= rdata;
                biu_icu_data_valid <= 1'b1;
                biu_icu_data_last  <= beat_last;
                biu_icu_fault      <= beat_fault;
                cnt_q              <= cnt_q + 1'b1;
                err_q              <= err_q | rresp[1];
            end else if (timeout) begin
                biu_icu_data       <= '0;
                biu_icu_data_valid <= 1'b1;
                biu_icu_data_last  <= 1'b1;
                biu_icu_fault      <= 1'b1;
            end
        end
    end

endmodule
